// File: rtl/bram_stream_reader.sv
// bram_stream_reader: streams a base/length window of BRAM words out over valid/ready with backpressure
module bram_stream_reader #(
  parameter int WADDR = 11,
  parameter int WDATA = 16
) (
  input  logic             pi_clk,
  input  logic             pi_rst,
  input  logic             pi_start,
  input  logic [WADDR-1:0] pi_base_addr,
  input  logic [WADDR:0]   pi_len,
  output logic             po_busy,
  output logic             po_done,
  output logic             po_bram_en,
  output logic             po_bram_we,
  output logic [WADDR-1:0] po_bram_addr,
  input  logic [WDATA-1:0] pi_bram_do,
  output logic [WDATA-1:0] po_data,
  output logic             po_valid,
  output logic             po_last,
  input  logic             pi_ready
);
  typedef enum logic [1:0] {IDLE, RUN, DRAIN, DONE} state_t;
  localparam logic [WADDR:0] ONE = 1;
  state_t           state_q;
  logic [WADDR-1:0] addr_q;
  logic [WADDR:0]   rem_q;
  logic             infl_q, infl_last_q;
  logic [1:0]       cnt_q;
  logic [WDATA-1:0] d0_q, d1_q;
  logic             l0_q, l1_q;
  logic             pop, issue, last_issue;
  logic [1:0]       widx;
  assign pop = (cnt_q != 2'd0) && pi_ready;
  assign issue = (state_q == RUN) && (rem_q != '0) &&
                 (({1'b0, cnt_q} + {2'b0, infl_q}) < (3'd2 + {2'b0, pop}));
  assign last_issue = issue && (rem_q == ONE);
  assign widx = cnt_q - {1'b0, pop};
  assign po_busy = state_q != IDLE;
  assign po_done = state_q == DONE;
  assign po_bram_en = issue;
  assign po_bram_we = 1'b0;
  assign po_bram_addr = addr_q;
  assign po_data = d0_q;
  assign po_valid = cnt_q != 2'd0;
  assign po_last = l0_q && po_valid;
  // Command FSM, address/remaining counters and the one-deep in-flight read tracker
  always_ff @(posedge pi_clk) begin
    if (pi_rst) begin
      state_q <= IDLE;
      addr_q <= '0;
      rem_q <= '0;
      infl_q <= 1'b0;
      infl_last_q <= 1'b0;
    end else begin
      infl_q <= issue;
      infl_last_q <= last_issue;
      if (issue) begin
        addr_q <= addr_q + WADDR'(1);
        rem_q <= rem_q - ONE;
      end
      case (state_q)
        IDLE: if (pi_start) begin
          addr_q <= pi_base_addr;
          rem_q <= pi_len;
          state_q <= (pi_len != '0) ? RUN : DONE;
        end
        RUN: if (last_issue) state_q <= DRAIN;
        DRAIN: if (!infl_q && (cnt_q == 2'd0 || (cnt_q == 2'd1 && pop))) state_q <= DONE;
        default: state_q <= IDLE;
      endcase
    end
  end
  // Two-entry output FIFO: head shifts on pop, returning read lands in the first free slot
  always_ff @(posedge pi_clk) begin
    if (pi_rst) begin
      cnt_q <= 2'd0;
      d0_q <= '0;
      d1_q <= '0;
      l0_q <= 1'b0;
      l1_q <= 1'b0;
    end else begin
      if (pop) begin
        d0_q <= d1_q;
        l0_q <= l1_q;
      end
      if (infl_q && widx == 2'd0) begin
        d0_q <= pi_bram_do;
        l0_q <= infl_last_q;
      end
      if (infl_q && widx == 2'd1) begin
        d1_q <= pi_bram_do;
        l1_q <= infl_last_q;
      end
      cnt_q <= cnt_q + {1'b0, infl_q} - {1'b0, pop};
    end
  end
endmodule

// File: tb/tb_bram_stream_reader.sv
// tb_bram_stream_reader: directed scoreboard bench for bram_stream_reader against a BRAM model
module tb_bram_stream_reader;
  localparam int WA = 11;
  localparam int WD = 16;
  localparam int DEPTH = 2 ** WA;
  logic          pi_clk = 1'b0;
  logic          pi_rst = 1'b1;
  logic          pi_start = 1'b0;
  logic [WA-1:0] pi_base_addr = '0;
  logic [WA:0]   pi_len = '0;
  logic          pi_ready = 1'b0;
  logic [WD-1:0] pi_bram_do = '0;
  logic          po_busy, po_done, po_bram_en, po_bram_we, po_valid, po_last;
  logic [WA-1:0] po_bram_addr;
  logic [WD-1:0] po_data;
  logic [WD-1:0] mem [DEPTH];
  logic [WA-1:0] qa[$];
  logic [WD:0]   qd[$];
  int  cyc = 0, nvec = 0, nerr = 0;
  int  tstart = 0, first_en = -1, first_vld = -1, done_off = -1, outst = 0, hs = 0;
  bit  mon = 1'b0, stalled = 1'b0;
  logic [WD:0] held = '0;
  logic [3:0]  pat = 4'b1001;

  bram_stream_reader #(.WADDR(WA), .WDATA(WD)) dut (
    .pi_clk(pi_clk), .pi_rst(pi_rst), .pi_start(pi_start), .pi_base_addr(pi_base_addr),
    .pi_len(pi_len), .po_busy(po_busy), .po_done(po_done), .po_bram_en(po_bram_en),
    .po_bram_we(po_bram_we), .po_bram_addr(po_bram_addr), .pi_bram_do(pi_bram_do),
    .po_data(po_data), .po_valid(po_valid), .po_last(po_last), .pi_ready(pi_ready)
  );

  always #5 pi_clk = ~pi_clk;
  always @(posedge pi_clk) cyc <= cyc + 1;
  always @(posedge pi_clk) if (po_bram_en) pi_bram_do <= mem[po_bram_addr];

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    nvec++;
    assert (obs === exp) else begin
      nerr++;
      $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
    end
  endtask

  always @(negedge pi_clk) if (mon) begin
    if (pi_start && !po_busy) begin
      tstart = cyc;
      first_en = -1;
      first_vld = -1;
    end
    if (po_bram_en) begin
      chk("occupancy", ((outst - int'(po_valid && pi_ready)) < 2) ? 1 : 0, 1);
      chk("we", po_bram_we, 0);
      if (first_en < 0) first_en = cyc;
      if (qa.size() == 0) chk("spurious_en", 1, 0);
      else chk("addr", po_bram_addr, qa.pop_front());
      outst++;
    end
    if (stalled) chk("valid_hold", po_valid, 1);
    if (po_valid) begin
      if (first_vld < 0) first_vld = cyc;
      if (stalled) chk("data_hold", {po_last, po_data}, held);
      if (pi_ready) begin
        if (qd.size() == 0) chk("spurious_data", 1, 0);
        else chk("data", {po_last, po_data}, qd.pop_front());
        outst--;
        hs++;
      end
      stalled = !pi_ready;
      held = {po_last, po_data};
    end else stalled = 1'b0;
    if (po_done && done_off >= 0) chk("done_cycle", cyc - tstart, done_off);
  end

  task automatic cmd(input int base, input int len);
    for (int i = 0; i < len; i++) begin
      logic [WA-1:0] a;
      a = WA'((base + i) % DEPTH);
      qa.push_back(a);
      qd.push_back({i == len - 1, mem[a]});
    end
    pi_start = 1'b1;
    pi_base_addr = WA'(base);
    pi_len = (WA + 1)'(len);
    @(posedge pi_clk); #1;
    pi_start = 1'b0;
  endtask

  task automatic wait_done(input bit bp, input int budget);
    bit seen;
    int i;
    seen = 1'b0;
    i = 0;
    while (!seen && i < budget) begin
      if (i > 0) begin
        @(posedge pi_clk); #1;
      end
      if (bp) pi_ready = pat[i % 4];
      @(negedge pi_clk);
      seen = po_done;
      i++;
    end
    chk("done_seen", seen, 1);
    @(posedge pi_clk); #1;
    pi_ready = 1'b1;
    chk("done_pulse", po_done, 0);
    chk("busy_after", po_busy, 0);
    chk("addr_q_empty", qa.size(), 0);
    chk("data_q_empty", qd.size(), 0);
  endtask

  task automatic chk_zero(input string tag);
    chk(tag, {po_busy, po_done, po_bram_en, po_bram_we, po_valid, po_last}, 0);
    chk({tag, "_data"}, po_data, 0);
    chk({tag, "_addr"}, po_bram_addr, 0);
  endtask

  initial begin
    for (int k = 0; k < DEPTH; k++) mem[k] = WD'(k + 100);
    repeat (3) @(posedge pi_clk);
    #1;
    chk_zero("reset");
    pi_rst = 1'b0;
    pi_ready = 1'b1;
    mon = 1'b1;
    @(posedge pi_clk); #1;
    done_off = 7;
    cmd(10, 4);
    wait_done(1'b0, 40);
    chk("first_en_lat", first_en - tstart, 1);
    chk("first_vld_lat", first_vld - tstart, 3);
    done_off = -1;
    cmd(10, 4);
    wait_done(1'b1, 60);
    done_off = 7;
    cmd(2046, 4);
    wait_done(1'b0, 40);
    done_off = 1;
    cmd(10, 0);
    wait_done(1'b0, 20);
    done_off = 11;
    cmd(300, 8);
    @(posedge pi_clk); #1;
    @(posedge pi_clk); #1;
    pi_start = 1'b1;
    pi_base_addr = WA'(500);
    pi_len = (WA + 1)'(3);
    @(posedge pi_clk); #1;
    pi_start = 1'b0;
    wait_done(1'b0, 40);
    done_off = -1;
    hs = 0;
    cmd(20, 8);
    for (int i = 0; i < 30 && hs < 2; i++) begin
      @(posedge pi_clk); #1;
    end
    chk("two_words", (hs >= 2) ? 1 : 0, 1);
    pi_rst = 1'b1;
    mon = 1'b0;
    qa.delete();
    qd.delete();
    outst = 0;
    stalled = 1'b0;
    @(posedge pi_clk); #1;
    chk_zero("mid_reset");
    pi_rst = 1'b0;
    mon = 1'b1;
    @(posedge pi_clk); #1;
    done_off = 5;
    cmd(0, 2);
    wait_done(1'b0, 40);
    $display("== %0d vectors applied, %0d miscompares ==", nvec, nerr);
    $finish;
  end
endmodule

// File: doc/bram_stream_reader.md
Name: bram_stream_reader

Overview:
- Sequential read engine sitting directly downstream of the dual-port BRAM.
- Drives one BRAM port, read-only: it supplies en/we/addr and receives the read data.
- Accepts a start command carrying a base address and a word count. Streams the words out over a valid/ready interface with full backpressure support.
- Feeds the SVM compute datapath (support vectors, coefficients) from BRAM contents.

Parameters:
- WADDR, 11, BRAM address width (depth 2**WADDR)
- WDATA, 16, BRAM data width

Ports:
- pi_clk  in  1  single clock; also drives the attached BRAM port
- pi_rst  in  1  synchronous active-high reset
- pi_start  in  1  command strobe, sampled only in IDLE
- pi_base_addr  in  WADDR  first word address, captured with pi_start
- pi_len  in  WADDR+1  word count, 0..2**WADDR, captured with pi_start
- po_busy  out  1  high from the cycle after an accepted start until done
- po_done  out  1  one-cycle pulse at command completion
- po_bram_en  out  1  BRAM port enable, asserted for each issued read
- po_bram_we  out  1  BRAM write enable, constant 0
- po_bram_addr  out  WADDR  BRAM read address
- pi_bram_do  in  WDATA  BRAM read data, valid one cycle after en
- po_data  out  WDATA  stream data
- po_valid  out  1  stream valid
- po_last  out  1  marks final word of the command, qualified by po_valid
- pi_ready  in  1  downstream ready

Behaviour:
- Reset values: every output is 0; FSM in IDLE; FIFO empty; counters 0; any in-flight read is discarded.
- BRAM timing: read latency is exactly 1 cycle. pi_bram_do is captured in the cycle after po_bram_en=1.
- Storage: a 2-entry output FIFO holds each word together with its last flag. po_data, po_valid and po_last come from the FIFO head.
- Issue rule: a read is issued in a cycle only if all of these hold:
  - remaining count > 0
  - (fifo_count + inflight − pop) < 2, where pop = po_valid & pi_ready
  - This guarantees the FIFO never overflows.
- Address generation: the address increments by 1 per issued read and wraps modulo 2**WADDR (for WADDR=11, 2047 → 0).
- Last flag: the last tag is set on the read that decrements remaining from 1 to 0.
- FSM states and transitions:
  - IDLE: on pi_start=1, capture base and len.
    - len≠0 → RUN.
    - len=0 → DONE. No BRAM access occurs.
  - RUN: issue reads per the issue rule. When remaining reaches 0 → DRAIN.
  - DRAIN: wait until the FIFO is empty and nothing is in flight → DONE.
  - DONE: po_done=1 for exactly 1 cycle → IDLE.
- Busy: po_busy=1 in RUN, DRAIN and DONE; po_busy=0 in IDLE.
- Start while busy: pi_start outside IDLE is ignored. No state change occurs and no command is queued.
- Latency: with the start edge at cycle T, the first po_bram_en is in cycle T+1 and the first po_valid is in cycle T+3.
- Throughput: with pi_ready held high, one word is output per cycle with no bubbles. For a command of length N, po_done occurs in cycle T+N+3.
- Backpressure: while po_valid=1 and pi_ready=0, po_data and po_last hold stable. Reads stall once FIFO plus in-flight reaches 2.
- Simultaneous push and pop on a full FIFO is legal, and the count is unchanged.
- Reset mid-operation: pi_rst has priority over all other inputs. All state clears in the same edge, and the in-flight BRAM data is dropped. The next command starts clean.
- Width rules: remaining is WADDR+1 bits, so len=2**WADDR reads the entire memory once, wrapping back to base.

Test Plan:
- Preload mem[k]=k+100. Command base=10, len=4, pi_ready=1 → addresses 10,11,12,13 on consecutive cycles; po_data 110,111,112,113 on consecutive cycles; po_last only on 113; po_done exactly 1 cycle after the last handshake; po_busy low thereafter.
- Same command with pi_ready toggling 1,0,0,1,… → no word lost or duplicated; po_data stable while stalled; po_bram_en never issues when FIFO plus in-flight is 2.
- Command base=2046, len=4 → addresses 2046, 2047, 0, 1; data in that order.
- Command len=0 → no po_bram_en and no po_valid; po_done pulses 1 cycle after start.
- pi_start pulsed mid-RUN with base=500 → ignored; the original stream completes unchanged.
- pi_rst asserted after 2 words of a len=8 command → all outputs 0 the next cycle; a new command base=0, len=2 streams mem[0], mem[1] correctly.
